// File: rtl/fifo_access_sched.sv
// Access scheduler in front of a single-port-per-cycle synchronous FIFO: round-robin write
// arbitration among producers, read service for one consumer, shadow occupancy and status check.
module fifo_access_sched #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned LW   = $clog2(DEPTH) + 1,
  localparam int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NREQ-1:0]      req_valid_i,
  input  logic [NREQ*DW-1:0]   req_data_i,
  output logic [NREQ-1:0]      req_ready_o,
  input  logic                 rd_req_i,
  output logic                 rd_valid_o,
  output logic [DW-1:0]        rd_data_o,
  output logic                 fifo_rst_o,
  output logic                 fifo_wr_o,
  output logic                 fifo_rd_o,
  output logic [DW-1:0]        fifo_din_o,
  input  logic [DW-1:0]        fifo_dout_i,
  input  logic                 fifo_full_i,
  input  logic                 fifo_empty_i,
  output logic [LW-1:0]        level_o,
  output logic                 err_o
);

  typedef enum logic {OpRead, OpWrite} op_e;

  logic [PW-1:0] rr_ptr_q, rr_ptr_d, grant_idx, idx;
  logic          grant_found, wr_cand, rd_cand, wr_issue, rd_issue;
  op_e           last_op_q, last_op_d;
  logic [LW-1:0] level_q, level_d;
  logic          rd_pend_q, err_q, err_d, chk_mask_q, status_bad;
  logic [DW-1:0] req_data_arr [NREQ];

  always_comb begin
    for (int i = 0; i < int'(NREQ); i++) begin
      req_data_arr[i] = req_data_i[i*DW +: DW];
    end
  end

  // Round-robin search starting at rr_ptr_q; first valid requester wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      idx = PW'((int'(rr_ptr_q) + k) % int'(NREQ));
      if (!grant_found && req_valid_i[idx]) begin
        grant_found = 1'b1;
        grant_idx   = idx;
      end
    end
  end

  always_comb begin
    wr_cand = grant_found & ~fifo_full_i & (level_q != LW'(DEPTH));
    rd_cand = rd_req_i & ~fifo_empty_i & (level_q != '0);
    if (wr_cand && rd_cand) begin
      wr_issue = rst_ni & (last_op_q == OpRead);
      rd_issue = rst_ni & (last_op_q == OpWrite);
    end else begin
      wr_issue = rst_ni & wr_cand;
      rd_issue = rst_ni & rd_cand;
    end
  end

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    last_op_d = last_op_q;
    level_d   = level_q;
    if (wr_issue) begin
      rr_ptr_d  = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
      last_op_d = OpWrite;
      level_d   = level_q + 1'b1;
    end else if (rd_issue) begin
      last_op_d = OpRead;
      level_d   = level_q - 1'b1;
    end
    status_bad = ((level_q == LW'(DEPTH)) != fifo_full_i) || ((level_q == '0) != fifo_empty_i);
    err_d      = err_q | (status_bad & ~chk_mask_q);
  end

  always_comb begin
    req_ready_o = '0;
    if (wr_issue) begin
      req_ready_o[grant_idx] = 1'b1;
    end
    fifo_din_o = wr_issue ? req_data_arr[grant_idx] : '0;
  end

  assign fifo_wr_o  = wr_issue;
  assign fifo_rd_o  = rd_issue;
  assign fifo_rst_o = ~rst_ni;
  assign rd_valid_o = rd_pend_q;
  assign rd_data_o  = fifo_dout_i;
  assign level_o    = level_q;
  assign err_o      = err_q;

  // chk_mask_q hides the first edge after release, while the FIFO may still be settling.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q   <= '0;
      last_op_q  <= OpRead;
      level_q    <= '0;
      rd_pend_q  <= 1'b0;
      err_q      <= 1'b0;
      chk_mask_q <= 1'b1;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      last_op_q  <= last_op_d;
      level_q    <= level_d;
      rd_pend_q  <= rd_issue;
      err_q      <= err_d;
      chk_mask_q <= 1'b0;
    end
  end

endmodule
